// File: rtl/alu_seq_pkg.sv
// Shared codes for the ALU operation sequencer: ALUOp classes, operation codes,
// FSM states and the start-time decoder.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    AOP_RTYPE = 4'b0000,
    AOP_ADD   = 4'b0001,
    AOP_AND   = 4'b0010,
    AOP_OR    = 4'b0011,
    AOP_SUB   = 4'b0100,
    AOP_LW    = 4'b0111,
    AOP_SW    = 4'b1000,
    AOP_BEQ   = 4'b1001,
    AOP_BNE   = 4'b1010,
    AOP_BLT   = 4'b1011,
    AOP_BGT   = 4'b1100
  } aluop_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SLT = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_MUL = 4'b0111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GT   = 3'd4
  } br_e;

  typedef struct packed {
    op_e  op;
    br_e  br;
    logic illegal;
  } dec_t;

  // Unknown ALUOp classes fall back to add and are flagged illegal.
  function automatic dec_t decode(input logic [3:0] alu_op, input logic [2:0] funct);
    dec_t d;
    d.op      = OP_ADD;
    d.br      = BR_NONE;
    d.illegal = 1'b0;
    case (alu_op)
      AOP_RTYPE: begin
        case (funct)
          3'b000:  d.op = OP_ADD;
          3'b001:  d.op = OP_SUB;
          3'b010:  d.op = OP_AND;
          3'b011:  d.op = OP_OR;
          3'b100:  d.op = OP_SLT;
          3'b101:  d.op = OP_SLL;
          3'b110:  d.op = OP_SRL;
          3'b111:  d.op = OP_MUL;
          default: d.op = OP_ADD;
        endcase
      end
      AOP_ADD, AOP_LW, AOP_SW: d.op = OP_ADD;
      AOP_AND: d.op = OP_AND;
      AOP_OR:  d.op = OP_OR;
      AOP_SUB: d.op = OP_SUB;
      AOP_BEQ: begin d.op = OP_SUB; d.br = BR_EQ; end
      AOP_BNE: begin d.op = OP_SUB; d.br = BR_NE; end
      AOP_BLT: begin d.op = OP_SUB; d.br = BR_LT; end
      AOP_BGT: begin d.op = OP_SUB; d.br = BR_GT; end
      default: begin d.op = OP_ADD; d.illegal = 1'b1; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits
// of the product. The first bit is consumed on the start edge itself.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = SHW + 1;

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic             done_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      run_r    <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      acc_r    <= b[0] ? a : '0;
      mcand_r  <= a << 1;
      mplier_r <= b >> 1;
      cnt_r    <= CW'(1);
      run_r    <= 1'b1;
      done_r   <= 1'b0;
    end else if (run_r) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      // Last bit lands WIDTH-1 edges after start, so done rises one edge earlier than the top's done.
      if (cnt_r == CW'(WIDTH - 1)) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        run_r  <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes ALUOp/funct on start, runs single-cycle ops
// in one cycle and multiplies iteratively, presenting registered results.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       operation,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);

  state_e           state_r, state_next;
  dec_t             dec_s;
  logic             accept_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             branch_s;

  logic             busy_r, done_r, zero_r, branch_r, illegal_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       operation_r;

  assign dec_s       = decode(alu_op, funct);
  assign accept_s    = start && !busy_r && (state_r == S_IDLE);
  assign mul_start_s = accept_s && (dec_s.op == OP_MUL);

  // Single-cycle datapath, evaluated on the operands present at the accept edge.
  always_comb begin
    alu_res_s = '0;
    case (dec_s.op)
      OP_ADD:  alu_res_s = a + b;
      OP_SUB:  alu_res_s = a - b;
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res_s = a << b[SHW-1:0];
      OP_SRL:  alu_res_s = a >> b[SHW-1:0];
      default: alu_res_s = '0;
    endcase
  end

  // Branch decision for the branch ALUOp classes.
  always_comb begin
    branch_s = 1'b0;
    case (dec_s.br)
      BR_EQ:   branch_s = (a == b);
      BR_NE:   branch_s = (a != b);
      BR_LT:   branch_s = ($signed(a) < $signed(b));
      BR_GT:   branch_s = ($signed(a) > $signed(b));
      default: branch_s = 1'b0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next = (dec_s.op == OP_MUL) ? S_MUL : S_EXEC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_EXEC: state_next = S_IDLE;
      S_MUL: begin
        if (mul_done_s) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_MUL;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output registers; only a completing operation updates the result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
      operation_r <= 4'b0000;
      zero_r      <= 1'b1;
      branch_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (accept_s && (dec_s.op != OP_MUL)) begin
      busy_r      <= 1'b1;
      done_r      <= 1'b1;
      result_r    <= alu_res_s;
      operation_r <= dec_s.op;
      zero_r      <= (alu_res_s == '0);
      branch_r    <= branch_s;
      illegal_r   <= dec_s.illegal;
    end else if (accept_s) begin
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if ((state_r == S_MUL) && mul_done_s) begin
      busy_r      <= 1'b1;
      done_r      <= 1'b1;
      result_r    <= mul_product_s;
      operation_r <= OP_MUL;
      zero_r      <= (mul_product_s == '0);
      branch_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      // Busy drops the cycle after done, so a start in the done cycle is never taken.
      busy_r <= (state_r == S_MUL);
      done_r <= 1'b0;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign result       = result_r;
  assign operation    = operation_r;
  assign zero         = zero_r;
  assign branch_taken = branch_r;
  assign illegal      = illegal_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_op = 4'd0;
  logic [2:0]   funct = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero, branch_taken, illegal;
  logic [W-1:0] result;
  logic [3:0]   operation;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .operation(operation), .zero(zero), .branch_taken(branch_taken),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   opc;
    logic         br;
    logic         ill;
    logic         mul;
  } exp_t;

  function automatic exp_t ref_op(logic [3:0] op, logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y);
    exp_t r;
    int sh;
    sh = int'(y % 32);
    r = '0;
    if (op == 4'd0) begin
      r.opc = {1'b0, f};
      case (f)
        3'd0: r.res = x + y;
        3'd1: r.res = x - y;
        3'd2: r.res = x & y;
        3'd3: r.res = x | y;
        3'd4: r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        3'd5: r.res = x << sh;
        3'd6: r.res = x >> sh;
        default: begin r.res = x * y; r.mul = 1'b1; end
      endcase
    end else if (op == 4'd1 || op == 4'd7 || op == 4'd8) begin
      r.opc = 4'd0; r.res = x + y;
    end else if (op == 4'd2) begin
      r.opc = 4'd2; r.res = x & y;
    end else if (op == 4'd3) begin
      r.opc = 4'd3; r.res = x | y;
    end else if (op == 4'd4 || (op >= 4'd9 && op <= 4'd12)) begin
      r.opc = 4'd1; r.res = x - y;
      if (op == 4'd9)  r.br = (x == y);
      if (op == 4'd10) r.br = (x != y);
      if (op == 4'd11) r.br = ($signed(x) < $signed(y));
      if (op == 4'd12) r.br = ($signed(x) > $signed(y));
    end else begin
      r.opc = 4'd0; r.res = x + y; r.ill = 1'b1;
    end
    return r;
  endfunction

  // Reference model: cycles left in the current operation and the visible outputs.
  int           m_cnt = 0;
  logic         m_on = 1'b0;
  logic         e_done = 1'b0;
  exp_t         e_out = '0;
  exp_t         pend = '0;

  always @(posedge clk) begin
    m_on <= 1'b1;
    if (!rst_n) begin
      m_cnt  <= 0;
      e_done <= 1'b0;
      e_out  <= '0;
    end else if (m_cnt > 1) begin
      m_cnt  <= m_cnt - 1;
      e_done <= (m_cnt == 2);
      if (m_cnt == 2) e_out <= pend;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      e_done <= 1'b0;
    end else if (start) begin
      if (ref_op(alu_op, funct, a, b).mul) begin
        m_cnt  <= W + 1;
        pend   <= ref_op(alu_op, funct, a, b);
        e_done <= 1'b0;
      end else begin
        m_cnt  <= 1;
        e_out  <= ref_op(alu_op, funct, a, b);
        e_done <= 1'b1;
      end
    end else begin
      e_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("done", 64'(done), 64'(e_done));
      chk("result", 64'(result), 64'(e_out.res));
      chk("operation", 64'(operation), 64'(e_out.opc));
      chk("zero", 64'(zero), 64'(e_out.res == '0));
      chk("branch", 64'(branch_taken), 64'(e_out.br));
      chk("illegal", 64'(illegal), 64'(e_out.ill));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    alu_op = op; funct = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; alu_op = 4'($urandom); funct = 3'($urandom);
  endtask

  initial begin
    int cyc;
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd0, 3'd0, 32'd7, 32'd5);
    chk("add_done", 64'(done), 64'd1);
    chk("add_result", 64'(result), 64'd12);
    chk("add_zero", 64'(zero), 64'd0);
    @(negedge clk);
    issue(4'd9, 3'd0, 32'h1234, 32'h1234);
    chk("beq_zero", 64'(zero), 64'd1);
    chk("beq_taken", 64'(branch_taken), 64'd1);
    @(negedge clk);
    issue(4'd11, 3'd0, 32'hFFFF_FFFF, 32'd1);
    chk("blt_taken", 64'(branch_taken), 64'd1);
    @(negedge clk);
    issue(4'd15, 3'd0, 32'd3, 32'd4);
    chk("illegal_flag", 64'(illegal), 64'd1);
    chk("illegal_op", 64'(operation), 64'd0);
    @(negedge clk);
    issue(4'd0, 3'd5, 32'd1, 32'h25);
    chk("sll_result", 64'(result), 64'h20);
    @(negedge clk);

    issue(4'd0, 3'd7, 32'hFFFF, 32'h10001);
    cyc = 1;
    while (!done && cyc < 100) begin
      start = (cyc == 5 || cyc == 20);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("mul_latency", 64'(cyc), 64'd33);
    chk("mul_result", 64'(result), 64'hFFFF_FFFF);
    chk("mul_op", 64'(operation), 64'd7);
    @(negedge clk);

    issue(4'd0, 3'd7, $urandom, $urandom);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      alu_op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      funct  = 3'($urandom);
      a      = $urandom;
      b      = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      rst_n  = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port alu_op  input  4  ALUOp class code.
REQ-007 SHALL have port funct  input  3  R-type function select.
REQ-008 SHALL have ports a, b  input  WIDTH  operands, two's complement.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port operation  output  4  registered decoded ALU operation code.
REQ-013 SHALL have ports zero, branch_taken, illegal  output  1 each  result==0, branch decision, undefined alu_op/funct.

Function
REQ-014 SHALL decode on start: R-type (0000) funct 000 add(0000), 001 sub(0001), 010 and(0010), 011 or(0011), 100 slt(0100), 101 sll(0101), 110 srl(0110), 111 mul(0111).
REQ-015 SHALL decode alu_op 0001 add, 0010 and, 0011 or, 0100 sub, 0111/1000 add (lw/sw), 1001-1100 sub (beq/bne/blt/bgt); any other alu_op -> add with illegal=1.
REQ-016 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or IDLE -> MUL (mul); EXEC -> IDLE after 1 cycle; MUL -> IDLE after WIDTH cycles.
REQ-017 SHALL latch a, b, alu_op, funct on start in IDLE; later input changes have no effect.
REQ-018 SHALL give single-cycle latency: done=1 and result valid in the cycle after start is sampled.
REQ-019 SHALL give mul latency WIDTH+1: done asserted WIDTH+1 cycles after start; result = low WIDTH bits of a*b (iterative shift-add, one bit per cycle).
REQ-020 SHALL compute add/sub modulo 2^WIDTH; slt = 1 if signed a<b else 0; sll/srl by b[SHW-1:0], zero fill.
REQ-021 SHALL compute branch_taken from latched operands: beq a==b, bne a!=b, blt signed a<b, bgt signed a>b; 0 for all other ops.
REQ-022 SHALL hold busy=1 from the cycle after start until the done cycle inclusive; busy=0 in IDLE.
REQ-023 SHALL ignore start while busy=1 (no queueing, no state change).
REQ-024 SHALL accept a new start in the same cycle done=1 is asserted? No: start in done cycle is ignored; earliest next accept is cycle after done.
REQ-025 SHALL hold result, operation, zero, branch_taken, illegal stable from done until the next done.

Reset
REQ-026 SHALL, with rst_n=0 at a rising edge, set state IDLE, busy=0, done=0, result=0, operation=0000, zero=1, branch_taken=0, illegal=0.
REQ-027 SHALL abort any in-flight operation (including MUL) on reset without asserting done.

Structure
REQ-028 SHALL place ALUOp codes, operation codes and FSM state enum in shared package alu_seq_pkg.
REQ-029 SHALL implement the iterative multiplier as sub-module alu_mul_iter (WIDTH param, start/done, operands, product low half).

Verification
REQ-030 WIDTH=32, start alu_op=0000 funct=000 a=7 b=5 -> next cycle done=1, result=12, operation=0000, zero=0.
REQ-031 alu_op=1001 a=b=0x1234 -> done next cycle, result=0, zero=1, branch_taken=1; alu_op=1011 a=-1 b=1 -> branch_taken=1.
REQ-032 funct=111 a=0xFFFF b=0x10001 -> busy 33 cycles, done at cycle 33, result=0xFFFFFFFF; start pulses mid-op ignored.
REQ-033 alu_op=1111 -> done next cycle, illegal=1, operation=0000; funct=101 a=1 b=0x25 -> result=0x20 (shift by 5).
REQ-034 rst_n=0 at cycle 10 of mul -> next cycle busy=0, done=0, result=0; no done pulse ever for aborted op.
